// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, NOP encoding,
// default reset address and fetch FSM state encoding.
package if_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP          = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_KILL = 2'd1,
    ST_IDLE = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_out_buf.sv
// Output slot presented to IF/ID plus a one-entry pending slot that absorbs
// the response still in flight when the consumer stalls.
module if_out_buf
  import if_fetch_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            deliver_i,
  input  logic [XLEN-1:0] pc4_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc4_o,
  output logic [XLEN-1:0] instr_o,
  output logic            pend_full_nxt_o
);

  logic            pend_v;
  logic [XLEN-1:0] pend_pc4;
  logic [XLEN-1:0] pend_instr;
  logic            consume;
  logic            out_free;

  assign consume  = valid_o && !stall_i;
  assign out_free = !valid_o || consume;

  // Lets the FSM park itself once the pending slot will be occupied.
  always_comb begin
    pend_full_nxt_o = 1'b0;
    if (!flush_i)
      pend_full_nxt_o = (pend_v && !consume) || (deliver_i && (pend_v || !out_free));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_o    <= 1'b0;
      pc4_o      <= '0;
      instr_o    <= NOP;
      pend_v     <= 1'b0;
      pend_pc4   <= '0;
      pend_instr <= NOP;
    end else if (consume && pend_v) begin
      valid_o <= 1'b1;
      pc4_o   <= pend_pc4;
      instr_o <= pend_instr;
      pend_v  <= deliver_i;
      if (deliver_i) begin
        pend_pc4   <= pc4_i;
        pend_instr <= instr_i;
      end
    end else if (deliver_i && out_free && !pend_v) begin
      valid_o <= 1'b1;
      pc4_o   <= pc4_i;
      instr_o <= instr_i;
    end else begin
      if (consume) begin
        valid_o <= 1'b0;
        pc4_o   <= '0;
        instr_o <= NOP;
      end
      if (deliver_i) begin
        pend_v     <= 1'b1;
        pend_pc4   <= pc4_i;
        pend_instr <= instr_i;
      end
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: single-outstanding imem handshake feeding IF/ID.
// Optional IF_PERF_EN adds fetch/kill/stall performance counters.
//
// state | meaning
// REQ   | request live, response will be delivered
// KILL  | request outstanding, response will be discarded (wrong path)
// IDLE  | no request, pending slot full waiting for consumer
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] pc4_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o
`ifdef IF_PERF_EN
  ,
  output logic [31:0]     perf_fetch_o,
  output logic [31:0]     perf_kill_o,
  output logic [31:0]     perf_stall_o
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            deliver;
  logic            pend_full_nxt;

  assign imem_req_o  = (state_q != ST_IDLE);
  assign imem_addr_o = addr_q;
  assign deliver     = (state_q == ST_REQ) && imem_ack_i && !redirect_i;

  if_out_buf u_out_buf (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .flush_i         (redirect_i),
    .deliver_i       (deliver),
    .pc4_i           (next_pc(addr_q)),
    .instr_i         (imem_rdata_i),
    .valid_o         (valid_o),
    .pc4_o           (pc4_o),
    .instr_o         (instr_o),
    .pend_full_nxt_o (pend_full_nxt)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tgt_d   = tgt_q;
    case (state_q)
      ST_REQ: begin
        if (redirect_i) begin
          if (imem_ack_i) begin
            addr_d = redirect_pc_i;
          end else begin
            // Address must not change mid-request; remember the target instead.
            tgt_d   = redirect_pc_i;
            state_d = ST_KILL;
          end
        end else if (imem_ack_i) begin
          addr_d = next_pc(addr_q);
          if (pend_full_nxt) state_d = ST_IDLE;
        end
      end
      ST_KILL: begin
        if (redirect_i) tgt_d = redirect_pc_i;
        if (imem_ack_i) begin
          addr_d  = redirect_i ? redirect_pc_i : tgt_q;
          state_d = ST_REQ;
        end
      end
      ST_IDLE: begin
        if (redirect_i) begin
          addr_d  = redirect_pc_i;
          state_d = ST_REQ;
        end else if (!pend_full_nxt) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_REQ;
      addr_q  <= RESET_PC;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
    end
  end

`ifdef IF_PERF_EN
  logic discard;
  assign discard = imem_ack_i &&
                   ((state_q == ST_KILL) || ((state_q == ST_REQ) && redirect_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fetch_o <= '0;
      perf_kill_o  <= '0;
      perf_stall_o <= '0;
    end else begin
      if (valid_o && !stall_i) perf_fetch_o <= perf_fetch_o + 32'd1;
      if (discard)             perf_kill_o  <= perf_kill_o + 32'd1;
      if (valid_o && stall_i)  perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios, then randomized memory latency,
// stalls and redirects checked against a program-order stream model.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc4;
  logic [31:0] instr;
  logic        valid;
`ifdef IF_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_kill;
  logic [31:0] perf_stall;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] exp_pc;
  int          n_consume;
  int          exp_kill;
  int          exp_stall;
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  logic        mem_kill;

  if_fetch dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .pc4_o         (pc4),
    .instr_o       (instr),
    .valid_o       (valid)
`ifdef IF_PERF_EN
    ,
    .perf_fetch_o  (perf_fetch),
    .perf_kill_o   (perf_kill),
    .perf_stall_o  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA000_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // zero-wait memory: acknowledge whatever is requested this cycle
  task automatic zw();
    imem_ack   = imem_req;
    imem_rdata = mem_word(imem_addr);
  endtask

  // leaves the bench in the reset-deassertion cycle
  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    tick(); tick();

    // zero-wait streaming after reset
    rst = 1'b0;
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_pc4", pc4, 32'h0);
    chk("rst_instr", instr, 32'h0);
    zw(); tick();
    chk("zw_c1_valid", {31'd0, valid}, 32'd1);
    chk("zw_c1_pc4", pc4, 32'd4);
    chk("zw_c1_instr", instr, 32'hA000_0000);
    zw(); tick();
    chk("zw_c2_pc4", pc4, 32'd8);
    chk("zw_c2_instr", instr, 32'hA000_0004);
    zw(); tick();
    chk("zw_c3_pc4", pc4, 32'd12);
    chk("zw_c3_instr", instr, 32'hA000_0008);

    // stall for 3 cycles while pc4=8
    do_reset();
    zw(); tick();
    zw(); tick();
    chk("st_c2_pc4", pc4, 32'd8);
    stall = 1'b1; zw(); tick();
    chk("st_c3_pc4", pc4, 32'd8);
    chk("st_c3_req", {31'd0, imem_req}, 32'd0);
    zw(); tick();
    chk("st_c4_pc4", pc4, 32'd8);
    chk("st_c4_req", {31'd0, imem_req}, 32'd0);
    zw(); tick();
    chk("st_c5_pc4", pc4, 32'd8);
    chk("st_c5_valid", {31'd0, valid}, 32'd1);
    stall = 1'b0; zw(); tick();
    chk("st_c6_pc4", pc4, 32'd12);
    chk("st_c6_instr", instr, 32'hA000_0008);
    chk("st_c6_req", {31'd0, imem_req}, 32'd1);
    chk("st_c6_addr", imem_addr, 32'd12);
    zw(); tick();
    chk("st_c7_pc4", pc4, 32'd16);
    zw(); tick();
    chk("st_c8_pc4", pc4, 32'd20);

    // redirect while a 3-cycle request is outstanding
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h10; zw(); tick();
    redirect = 1'b0; imem_ack = 1'b0;
    chk("kl_c1_addr", imem_addr, 32'h10);
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("kl_c3_addr", imem_addr, 32'h10);
    chk("kl_c3_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0010;
    tick();
    imem_ack = 1'b0;
    chk("kl_c4_addr", imem_addr, 32'h100);
    chk("kl_c4_valid", {31'd0, valid}, 32'd0);
    tick();
    chk("kl_c5_addr", imem_addr, 32'h100);
    chk("kl_c5_valid", {31'd0, valid}, 32'd0);
    tick();
    zw(); tick();
    imem_ack = 1'b0;
    chk("kl_c7_valid", {31'd0, valid}, 32'd1);
    chk("kl_c7_pc4", pc4, 32'h104);
    chk("kl_c7_instr", instr, mem_word(32'h100));

    // redirect in IDLE with pending full and stall held
    do_reset();
    zw(); tick();
    zw(); tick();
    stall = 1'b1; zw(); tick();
    chk("id_c3_req", {31'd0, imem_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h200; zw(); tick();
    redirect = 1'b0;
    chk("id_c4_valid", {31'd0, valid}, 32'd0);
    chk("id_c4_instr", instr, 32'h0);
    chk("id_c4_pc4", pc4, 32'h0);
    chk("id_c4_req", {31'd0, imem_req}, 32'd1);
    chk("id_c4_addr", imem_addr, 32'h200);
    stall = 1'b0; zw(); tick();
    chk("id_c5_pc4", pc4, 32'h204);
    chk("id_c5_instr", instr, mem_word(32'h200));

    // reset while in KILL; ack arriving with reset is dropped
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h300; imem_ack = 1'b0; tick();
    redirect = 1'b0;
    chk("rk_c1_addr", imem_addr, 32'h0);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick();
    rst = 1'b0; imem_ack = 1'b0;
    chk("rk_c2_addr", imem_addr, 32'h0);
    chk("rk_c2_req", {31'd0, imem_req}, 32'd1);
    chk("rk_c2_valid", {31'd0, valid}, 32'd0);
    tick();
    chk("rk_c3_valid", {31'd0, valid}, 32'd0);
    chk("rk_c3_addr", imem_addr, 32'h0);
    zw(); tick();
    imem_ack = 1'b0;
    chk("rk_c4_pc4", pc4, 32'd4);
    chk("rk_c4_instr", instr, 32'hA000_0000);

    // randomized traffic against a program-order stream model
    do_reset();
    exp_pc = 32'h0; n_consume = 0; exp_kill = 0; exp_stall = 0;
    mem_busy = 1'b0; mem_addr = '0; mem_cnt = 0; mem_kill = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!valid) begin
        chk("rnd_idle_pc4", pc4, 32'h0);
        chk("rnd_idle_instr", instr, 32'h0);
      end
      stall    = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);

      if (mem_busy) begin
        chk("rnd_req_held", {31'd0, imem_req}, 32'd1);
        chk("rnd_addr_stable", imem_addr, mem_addr);
      end else if (imem_req) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = $urandom_range(0, 3);
        mem_kill = 1'b0;
      end
      if (redirect && mem_busy) mem_kill = 1'b1;
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(mem_addr);
          if (mem_kill) exp_kill++;
          mem_busy = 1'b0;
        end else begin
          mem_cnt--;
        end
      end

      if (valid && stall) exp_stall++;
      if (valid && !stall) begin
        chk("rnd_pc4", pc4, exp_pc + 32'd4);
        chk("rnd_instr", instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_consume++;
      end
      if (redirect) exp_pc = redirect_pc;
      tick();
    end
    stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    chk("rnd_progress", {31'd0, (n_consume > 200)}, 32'd1);
`ifdef IF_PERF_EN
    chk("perf_fetch", perf_fetch, n_consume);
    chk("perf_kill", perf_kill, exp_kill);
    chk("perf_stall", perf_stall, exp_stall);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
